// File: rtl/seq_frame_det_if.sv
// seq_frame_det_if: serial bit stream, sync-pattern control and
// detection/frame result bundle for the serial-receive path.
interface seq_frame_det_if #(
    parameter int PAT_W     = 8,
    parameter int NUM_BYTES = 4,
    parameter int CNT_W     = 8
);
    logic                   bit_vld;
    logic                   bit_in;
    logic [PAT_W-1:0]       pattern;
    logic [PAT_W-1:0]       pat_mask;
    logic                   overlap;
    logic                   frame_en;
    logic                   det_pulse;
    logic [CNT_W-1:0]       det_cnt;
    logic                   busy;
    logic                   frame_vld;
    logic [8*NUM_BYTES-1:0] frame_data;
    logic                   check_ok;

    modport master (
        output bit_vld, bit_in, pattern, pat_mask, overlap, frame_en,
        input  det_pulse, det_cnt, busy, frame_vld, frame_data, check_ok
    );

    modport slave (
        input  bit_vld, bit_in, pattern, pat_mask, overlap, frame_en,
        output det_pulse, det_cnt, busy, frame_vld, frame_data, check_ok
    );
endinterface

// File: rtl/seq_frame_det.sv
// seq_frame_det: maskable sync-pattern hunter with optional fixed-length
// payload capture and XOR checksum check on a single-bit stream.
module seq_frame_det #(
    parameter int PAT_W     = 8,
    parameter int NUM_BYTES = 4,
    parameter int CNT_W     = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_frame_det_if.slave bus
);
    localparam int TOT = 8 * NUM_BYTES;
    localparam int FW  = $clog2(PAT_W + 1);
    localparam int BW  = $clog2(TOT);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [PAT_W-1:0] sr_q, sr_n, sr_shift;
    logic [FW-1:0]    fill_q, fill_n, fill_inc;
    logic [BW-1:0]    bcnt_q, bcnt_n;
    logic [TOT-1:0]   pay_q, pay_n;
    logic [TOT-1:0]   fdata_q, fdata_n, fdata_c;
    logic             pulse_q, pulse_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             fvld_q, fvld_n;
    logic             ok_q, ok_n, ok_c;
    logic             busy_q;
    logic             match;
    logic [7:0]       acc;

    // Next-state and next-output logic; payload bits never reach the hunter.
    always_comb begin
        state_n  = state_q;
        sr_n     = sr_q;
        fill_n   = fill_q;
        bcnt_n   = bcnt_q;
        pay_n    = pay_q;
        fdata_n  = fdata_q;
        ok_n     = ok_q;
        cnt_n    = cnt_q;
        pulse_n  = 1'b0;
        fvld_n   = 1'b0;
        fdata_c  = '0;
        acc      = '0;
        ok_c     = 1'b0;
        sr_shift = {sr_q[PAT_W-2:0], bus.bit_in};
        fill_inc = (fill_q == FW'(PAT_W)) ? fill_q : fill_q + 1'b1;
        match    = bus.bit_vld && (state_q == HUNT)
                && (fill_inc >= FW'(PAT_W))
                && (((sr_shift ^ bus.pattern) & bus.pat_mask) == '0);

        unique case (state_q)
            HUNT: begin
                if (bus.bit_vld) begin
                    sr_n   = sr_shift;
                    fill_n = fill_inc;
                end
                if (match) begin
                    pulse_n = 1'b1;
                    cnt_n   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    if (bus.frame_en) begin
                        state_n = PAYLOAD;
                        bcnt_n  = '0;
                        sr_n    = '0;
                        fill_n  = '0;
                    end else if (!bus.overlap) begin
                        sr_n   = '0;
                        fill_n = '0;
                    end
                end
            end
            PAYLOAD: begin
                if (bus.bit_vld) begin
                    pay_n = {pay_q[TOT-2:0], bus.bit_in};
                    if (bcnt_q == BW'(TOT - 1)) begin
                        for (int k = 0; k < NUM_BYTES; k++) begin
                            fdata_c[8*k +: 8] = pay_n[8*(NUM_BYTES-1-k) +: 8];
                        end
                        for (int k = 0; k < NUM_BYTES - 1; k++) begin
                            acc = acc ^ fdata_c[8*k +: 8];
                        end
                        ok_c    = (acc == fdata_c[8*(NUM_BYTES-1) +: 8]);
                        state_n = DONE;
                        bcnt_n  = '0;
                        fvld_n  = 1'b1;
                        fdata_n = fdata_c;
                        ok_n    = ok_c;
                    end else begin
                        bcnt_n = bcnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = HUNT;
            end
            default: begin
                state_n = HUNT;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            sr_q    <= '0;
            fill_q  <= '0;
            bcnt_q  <= '0;
            pay_q   <= '0;
            fdata_q <= '0;
            ok_q    <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            fvld_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            sr_q    <= sr_n;
            fill_q  <= fill_n;
            bcnt_q  <= bcnt_n;
            pay_q   <= pay_n;
            fdata_q <= fdata_n;
            ok_q    <= ok_n;
            cnt_q   <= cnt_n;
            pulse_q <= pulse_n;
            fvld_q  <= fvld_n;
            busy_q  <= (state_n != HUNT);
        end
    end

    assign bus.det_pulse  = pulse_q;
    assign bus.det_cnt    = cnt_q;
    assign bus.busy       = busy_q;
    assign bus.frame_vld  = fvld_q;
    assign bus.frame_data = fdata_q;
    assign bus.check_ok   = ok_q;
endmodule

// File: tb/tb_seq_frame_det.sv
// tb_seq_frame_det: directed frames plus random stream against a
// queue-based reference model; two DUTs differ only in counter width.
module tb_seq_frame_det;
    localparam int PW = 8;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bit_vld = 1'b0;
    logic bit_in = 1'b0;
    logic [PW-1:0] pattern = '0;
    logic [PW-1:0] pat_mask = '0;
    logic overlap = 1'b0;
    logic frame_en = 1'b0;

    int checks = 0;
    int errors = 0;
    int pulse_seen = 0;
    int fvld_seen = 0;

    always #5 clk = ~clk;

    seq_frame_det_if #(.PAT_W(PW), .NUM_BYTES(NB), .CNT_W(8)) if0 ();
    seq_frame_det_if #(.PAT_W(PW), .NUM_BYTES(NB), .CNT_W(2)) if1 ();

    assign if0.bit_vld = bit_vld;
    assign if0.bit_in = bit_in;
    assign if0.pattern = pattern;
    assign if0.pat_mask = pat_mask;
    assign if0.overlap = overlap;
    assign if0.frame_en = frame_en;
    assign if1.bit_vld = bit_vld;
    assign if1.bit_in = bit_in;
    assign if1.pattern = pattern;
    assign if1.pat_mask = pat_mask;
    assign if1.overlap = overlap;
    assign if1.frame_en = frame_en;

    seq_frame_det #(.PAT_W(PW), .NUM_BYTES(NB), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave)
    );
    seq_frame_det #(.PAT_W(PW), .NUM_BYTES(NB), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave)
    );

    // reference model state
    bit hist[$];
    bit pay[$];
    bit m_in_frame = 0;
    bit m_done = 0;
    bit e_pulse = 0;
    bit e_fvld = 0;
    bit e_busy = 0;
    bit e_ok = 0;
    logic [31:0] e_fdata = '0;
    int e_cnt8 = 0;
    int e_cnt2 = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pat_hit();
        for (int i = 0; i < PW; i++) begin
            if (pat_mask[i] && (hist[PW-1-i] != pattern[i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic close_frame();
        logic [31:0] d;
        logic [7:0] b;
        logic [7:0] x;
        d = '0;
        x = '0;
        for (int k = 0; k < NB; k++) begin
            b = '0;
            for (int j = 0; j < 8; j++) b = {b[6:0], pay[8*k+j]};
            d[8*k +: 8] = b;
            if (k < NB - 1) x = x ^ b;
        end
        e_fdata = d;
        e_ok = (x == d[31:24]);
        e_fvld = 1;
        m_done = 1;
        m_in_frame = 0;
        pay.delete();
    endtask

    // Model advances on each rising edge using the inputs held since the falling edge.
    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            pay.delete();
            m_in_frame = 0;
            m_done = 0;
            e_pulse = 0;
            e_fvld = 0;
            e_busy = 0;
            e_ok = 0;
            e_fdata = '0;
            e_cnt8 = 0;
            e_cnt2 = 0;
        end else begin
            e_pulse = 0;
            e_fvld = 0;
            if (m_done) begin
                m_done = 0;
            end else if (m_in_frame) begin
                if (bit_vld) begin
                    pay.push_back(bit_in);
                    if (pay.size() == 8 * NB) close_frame();
                end
            end else if (bit_vld) begin
                hist.push_back(bit_in);
                if (hist.size() > PW) void'(hist.pop_front());
                if (hist.size() == PW && pat_hit()) begin
                    e_pulse = 1;
                    if (e_cnt8 < 255) e_cnt8++;
                    if (e_cnt2 < 3) e_cnt2++;
                    if (frame_en) begin
                        m_in_frame = 1;
                        hist.delete();
                        pay.delete();
                    end else if (!overlap) begin
                        hist.delete();
                    end
                end
            end
            e_busy = m_in_frame || m_done;
        end
    end

    // Every cycle: both DUTs against the model.
    always @(negedge clk) begin
        if (if0.det_pulse) pulse_seen++;
        if (if0.frame_vld) fvld_seen++;
        chk("det_pulse0", 64'(if0.det_pulse), 64'(e_pulse));
        chk("det_cnt0", 64'(if0.det_cnt), 64'(e_cnt8));
        chk("busy0", 64'(if0.busy), 64'(e_busy));
        chk("frame_vld0", 64'(if0.frame_vld), 64'(e_fvld));
        chk("frame_data0", 64'(if0.frame_data), 64'(e_fdata));
        chk("check_ok0", 64'(if0.check_ok), 64'(e_ok));
        chk("det_pulse1", 64'(if1.det_pulse), 64'(e_pulse));
        chk("det_cnt1", 64'(if1.det_cnt), 64'(e_cnt2));
        chk("busy1", 64'(if1.busy), 64'(e_busy));
        chk("frame_vld1", 64'(if1.frame_vld), 64'(e_fvld));
        chk("frame_data1", 64'(if1.frame_data), 64'(e_fdata));
    end

    task automatic cyc(input bit v, input bit b);
        @(negedge clk);
        bit_vld = v;
        bit_in = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0);
    endtask

    task automatic send_byte(input logic [7:0] v, input bit gap);
        for (int i = 7; i >= 0; i--) begin
            if (gap) cyc(0, 0);
            cyc(1, v[i]);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1;
        bit_vld = 0;
        for (int i = 0; i < n; i++) @(negedge clk);
        rst = 0;
        pulse_seen = 0;
        fvld_seen = 0;
    endtask

    task automatic send_frame(input logic [7:0] last, input bit gap);
        send_byte(8'hE8, gap);
        send_byte(8'hF0, gap);
        send_byte(8'h0F, gap);
        send_byte(8'hFF, gap);
        send_byte(last, gap);
        idle(3);
    endtask

    task automatic pin_frame(input string tag, input logic [31:0] d,
                             input bit ok, input int cnt, input int np,
                             input int nf);
        chk({tag, "_data"}, 64'(if0.frame_data), 64'(d));
        chk({tag, "_model_data"}, 64'(e_fdata), 64'(d));
        chk({tag, "_ok"}, 64'(if0.check_ok), 64'(ok));
        chk({tag, "_cnt"}, 64'(if0.det_cnt), 64'(cnt));
        chk({tag, "_model_cnt"}, 64'(e_cnt8), 64'(cnt));
        chk({tag, "_pulses"}, 64'(pulse_seen), 64'(np));
        chk({tag, "_frames"}, 64'(fvld_seen), 64'(nf));
    endtask

    initial begin
        do_reset(2);
        chk("rst_cnt", 64'(if0.det_cnt), 64'd0);
        chk("rst_busy", 64'(if0.busy), 64'd0);
        chk("rst_data", 64'(if0.frame_data), 64'd0);

        pattern = 8'hE8;
        pat_mask = 8'hFF;
        frame_en = 1;
        overlap = 0;
        send_frame(8'h00, 0);
        pin_frame("basic", 32'h00FF0FF0, 1, 1, 1, 1);

        send_frame(8'hAA, 0);
        pin_frame("badsum", 32'hAAFF0FF0, 0, 2, 2, 2);

        do_reset(2);
        pattern = 8'h0A;
        pat_mask = 8'h0F;
        frame_en = 0;
        overlap = 1;
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        idle(2);
        chk("ovl_pulses", 64'(pulse_seen), 64'd3);
        chk("ovl_cnt", 64'(if0.det_cnt), 64'd3);

        do_reset(2);
        overlap = 0;
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        idle(2);
        chk("novl_pulses", 64'(pulse_seen), 64'd1);
        chk("novl_cnt", 64'(if0.det_cnt), 64'd1);

        do_reset(2);
        pattern = 8'hE8;
        pat_mask = 8'hFF;
        frame_en = 1;
        send_frame(8'h00, 1);
        pin_frame("gap", 32'h00FF0FF0, 1, 1, 1, 1);

        send_byte(8'hE8, 1);
        send_byte(8'hF0, 1);
        cyc(1, 0);
        cyc(1, 0);
        chk("midrst_busy", 64'(if0.busy), 64'd1);
        do_reset(1);
        chk("midrst_cnt", 64'(if0.det_cnt), 64'd0);
        chk("midrst_busy0", 64'(if0.busy), 64'd0);
        chk("midrst_data", 64'(if0.frame_data), 64'd0);
        chk("midrst_ok", 64'(if0.check_ok), 64'd0);
        send_frame(8'h00, 0);
        pin_frame("after", 32'h00FF0FF0, 1, 1, 1, 1);

        do_reset(2);
        frame_en = 0;
        overlap = 1;
        pat_mask = 8'h00;
        for (int i = 0; i < 20; i++) cyc(1, 1'($urandom_range(0, 1)));
        idle(2);
        chk("sat_pulses", 64'(pulse_seen), 64'd13);
        chk("sat_cnt2", 64'(if1.det_cnt), 64'd3);
        chk("sat_cnt8", 64'(if0.det_cnt), 64'd13);

        do_reset(1);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 2));
            if ($urandom_range(0, 59) == 0) begin
                pattern = 8'($urandom);
                pat_mask = 8'($urandom & $urandom & $urandom);
                frame_en = 1'($urandom_range(0, 1));
                overlap = 1'($urandom_range(0, 1));
            end
            cyc($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)));
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
